// File: rtl/pio_out_blink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pio_out_blink: Avalon-MM LED output port with set/clear/toggle and blink.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pio_out_blink #(
  parameter int unsigned      WIDTH       = 9,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      DIV_WIDTH   = 24,
  parameter int unsigned      DIV_RESET   = 12500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             blink_tick
);

  localparam logic [2:0] c_addr_data  = 3'd0;
  localparam logic [2:0] c_addr_set   = 3'd1;
  localparam logic [2:0] c_addr_clr   = 3'd2;
  localparam logic [2:0] c_addr_tog   = 3'd3;
  localparam logic [2:0] c_addr_blink = 3'd4;
  localparam logic [2:0] c_addr_div   = 3'd5;
  localparam logic [2:0] c_addr_out   = 3'd6;

  localparam logic [DIV_WIDTH-1:0] c_div_reset = DIV_RESET[DIV_WIDTH-1:0];
  localparam logic [DIV_WIDTH-1:0] c_one       = 1;

  logic                 w_wr;
  logic [WIDTH-1:0]     w_wd;
  logic [DIV_WIDTH-1:0] w_wd_div;
  logic                 w_unused;

  logic [WIDTH-1:0]     r_data_out;
  logic [WIDTH-1:0]     r_blink;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_phase;
  logic                 r_blink_tick;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_wd_div = writedata[DIV_WIDTH-1:0];
  assign w_unused = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= RESET_VALUE;
      r_blink      <= '0;
      r_div        <= c_div_reset;
      r_cnt        <= c_div_reset;
      r_phase      <= 1'b0;
      r_blink_tick <= 1'b0;
    end else begin
      r_blink_tick <= 1'b0;

      if (w_wr) begin
        case (address)
          c_addr_data:  r_data_out <= w_wd;
          c_addr_set:   r_data_out <= r_data_out | w_wd;
          c_addr_clr:   r_data_out <= r_data_out & ~w_wd;
          c_addr_tog:   r_data_out <= r_data_out ^ w_wd;
          c_addr_blink: r_blink    <= w_wd;
          default:      ;
        endcase
      end

      // A DIV write overrides a coincident terminal count: no toggle, no tick.
      if (w_wr && (address == c_addr_div)) begin
        r_div   <= w_wd_div;
        r_cnt   <= w_wd_div;
        r_phase <= 1'b0;
      end else if (r_div == '0) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (r_cnt == '0) begin
        r_cnt        <= r_div;
        r_phase      <= ~r_phase;
        r_blink_tick <= 1'b1;
      end else begin
        r_cnt <= r_cnt - c_one;
      end
    end
  end

  // Blinking bits are forced off during phase 1.
  assign out_port   = r_data_out & ~(r_blink & {WIDTH{r_phase}});
  assign blink_tick = r_blink_tick;

  always_comb begin
    readdata = '0;
    case (address)
      c_addr_data:  readdata[WIDTH-1:0]     = r_data_out;
      c_addr_blink: readdata[WIDTH-1:0]     = r_blink;
      c_addr_div:   readdata[DIV_WIDTH-1:0] = r_div;
      c_addr_out:   readdata[WIDTH-1:0]     = out_port;
      default:      readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_out_blink.sv
`default_nettype none
// Directed bench for pio_out_blink: expected values are queued, then popped and
// compared against the DUT with immediate assertions.
module tb_pio_out_blink;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [8:0]  out_port;
  logic        blink_tick;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  pio_out_blink #(
    .WIDTH       (9),
    .RESET_VALUE (9'h0A5),
    .DIV_WIDTH   (24),
    .DIV_RESET   (12500000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .blink_tick (blink_tick)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        tests_failed++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
      end
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 v = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] rv;
  int unsigned k;
  logic ph, tick_seen, out_bad;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    push(32'h0A5); check("rst_out_port", {23'b0, out_port});
    push(32'h0);   check("rst_tick", {31'b0, blink_tick});
    bus_rd(3'd0, rv); push(32'h0A5);    check("rst_data", rv);
    bus_rd(3'd5, rv); push(32'd12500000); check("rst_div", rv);
    reset_n = 1'b1;
    @(negedge clk);
    push(32'h0A5); check("post_rst_out", {23'b0, out_port});

    // Data / set / clear / toggle
    bus_wr(3'd0, 32'h1FF, 1'b1);
    push(32'h1FF); check("data_wr", {23'b0, out_port});
    bus_wr(3'd2, 32'h00F, 1'b1);
    bus_rd(3'd0, rv); push(32'h1F0); check("clr_data", rv);
    bus_rd(3'd6, rv); push(32'h1F0); check("clr_out", rv);
    bus_wr(3'd1, 32'h001, 1'b1);
    bus_rd(3'd0, rv); push(32'h1F1); check("set_data", rv);
    bus_wr(3'd3, 32'h180, 1'b1);
    bus_rd(3'd0, rv); push(32'h071); check("tog_data", rv);
    push(32'h071); check("tog_out", {23'b0, out_port});
    for (int a = 1; a <= 3; a++) begin
      bus_rd(a[2:0], rv); push(32'h0); check("wo_reads_0", rv);
    end

    // Blinking with DIV=3: half-period of 4 clocks
    bus_wr(3'd4, 32'h003, 1'b1);
    bus_wr(3'd0, 32'h007, 1'b1);
    bus_wr(3'd5, 32'd3, 1'b1);
    push(32'h007); check("blink_start", {23'b0, out_port});
    for (k = 1; k <= 14; k++) begin
      @(negedge clk);
      ph = ((k / 4) % 2) == 1;
      push(ph ? 32'h004 : 32'h007);
      push((k % 4) == 0 ? 32'h1 : 32'h0);
      push(ph ? 32'h004 : 32'h007);
      check("blink_out", {23'b0, out_port});
      check("blink_tick", {31'b0, blink_tick});
      bus_rd(3'd6, rv); check("blink_outreg", rv);
    end

    // DIV=0 while in phase 1 stops blinking
    push(32'h004); check("pre_div0_phase1", {23'b0, out_port});
    bus_wr(3'd5, 32'd0, 1'b1);
    bus_rd(3'd5, rv); push(32'h0); check("div0_read", rv);
    tick_seen = 1'b0; out_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (blink_tick) tick_seen = 1'b1;
      if (out_port !== 9'h007) out_bad = 1'b1;
      @(negedge clk);
    end
    push(32'h0); check("div0_no_tick", {31'b0, tick_seen});
    push(32'h0); check("div0_out_bad", {31'b0, out_bad});

    // DIV write on the terminal-count cycle wins
    bus_wr(3'd5, 32'd5, 1'b1);
    repeat (5) @(negedge clk);
    push(32'h0); check("tc_pre_tick", {31'b0, blink_tick});
    bus_wr(3'd5, 32'd2, 1'b1);
    push(32'h0);   check("tc_no_tick", {31'b0, blink_tick});
    push(32'h007); check("tc_phase0", {23'b0, out_port});
    @(negedge clk);
    push(32'h0); check("tc_tick_e7", {31'b0, blink_tick});
    @(negedge clk);
    push(32'h0); check("tc_tick_e8", {31'b0, blink_tick});
    @(negedge clk);
    push(32'h1);   check("tc_tick_e9", {31'b0, blink_tick});
    push(32'h004); check("tc_phase1", {23'b0, out_port});

    // Asynchronous reset mid-blink in phase 1
    #2 reset_n = 1'b0;
    #1;
    push(32'h0A5); check("async_rst_out", {23'b0, out_port});
    push(32'h0);   check("async_rst_tick", {31'b0, blink_tick});
    bus_rd(3'd4, rv); push(32'h0);        check("async_rst_blink", rv);
    bus_rd(3'd5, rv); push(32'd12500000); check("async_rst_div", rv);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Ignored writes
    bus_wr(3'd0, 32'h000, 1'b0);
    bus_rd(3'd0, rv); push(32'h0A5); check("cs0_data", rv);
    bus_wr(3'd7, 32'h1FF, 1'b1);
    bus_rd(3'd0, rv); push(32'h0A5);      check("a7_data", rv);
    bus_rd(3'd4, rv); push(32'h0);        check("a7_blink", rv);
    bus_rd(3'd5, rv); push(32'd12500000); check("a7_div", rv);
    bus_rd(3'd7, rv); push(32'h0);        check("a7_read", rv);

    // Upper write-data bits are dropped
    bus_wr(3'd0, 32'hFFFF_FE00, 1'b1);
    bus_rd(3'd0, rv); push(32'h0);   check("wide_data", rv);
    bus_wr(3'd4, 32'hFFFF_FFFF, 1'b1);
    bus_rd(3'd4, rv); push(32'h1FF); check("wide_blink", rv);
    bus_wr(3'd5, 32'hFF00_0002, 1'b1);
    bus_rd(3'd5, rv); push(32'h2);   check("wide_div", rv);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
